gamepad_pmod_multi: RTL and testbench

Parametrised successor to the single/dual Gamepad Pmod interface. It receives the Pmod serial stream (data/clk/latch) and validates frame length. It decodes up to NUM_PADS controllers and produces per-button level, press and release event outputs, plus per-pad presence and link-timeout status. It sits between the ui_in Pmod pins and game/VGA logic in Tiny Tapeout designs.

---
 rtl/gamepad_pmod_pkg.sv | 26 ++
 rtl/gamepad_pmod_sync_edge.sv | 28 ++
 rtl/gamepad_pmod_multi.sv | 133 +++++++++++++
 tb/tb_gamepad_pmod_multi.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gamepad_pmod_pkg.sv
// rtl/gamepad_pmod_pkg.sv - shared constants and types for the gamepad Pmod receiver
package gamepad_pmod_pkg;

  // Bit positions within one pad's 12-bit slice
  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  localparam int BITS_PER_PAD = 12;
  localparam logic [BITS_PER_PAD-1:0] EMPTY_PAD = 12'hFFF;

  typedef enum logic {
    NO_LINK = 1'b0,
    LINK    = 1'b1
  } link_state_e;

endpackage

// File: rtl/gamepad_pmod_sync_edge.sv
// rtl/gamepad_pmod_sync_edge.sv - multi-stage synchroniser with falling-edge detect
module gamepad_pmod_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync_out,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign fall     = prev & ~chain[STAGES-1];

endmodule

// File: rtl/gamepad_pmod_multi.sv
// rtl/gamepad_pmod_multi.sv - Pmod gamepad chain receiver: framing, per-pad decode, events, link watchdog
module gamepad_pmod_multi
  import gamepad_pmod_pkg::*;
#(
  parameter int NUM_PADS       = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pmod_data,
  input  logic                             pmod_clk,
  input  logic                             pmod_latch,
  output logic [BITS_PER_PAD*NUM_PADS-1:0] buttons,
  output logic [BITS_PER_PAD*NUM_PADS-1:0] pressed,
  output logic [BITS_PER_PAD*NUM_PADS-1:0] released,
  output logic [NUM_PADS-1:0]              is_present,
  output logic                             frame_valid,
  output logic                             frame_err,
  output logic                             stale
);

  localparam int W  = BITS_PER_PAD * NUM_PADS;
  localparam int CW = $clog2(W + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic data_sync, clk_fall, latch_fall;
  logic data_fall_unused, clk_sync_unused, latch_sync_unused;

  gamepad_pmod_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .reset(reset), .din(pmod_data),
    .sync_out(data_sync), .fall(data_fall_unused)
  );

  gamepad_pmod_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .reset(reset), .din(pmod_clk),
    .sync_out(clk_sync_unused), .fall(clk_fall)
  );

  gamepad_pmod_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .clk(clk), .reset(reset), .din(pmod_latch),
    .sync_out(latch_sync_unused), .fall(latch_fall)
  );

  logic [W-1:0]        shift_reg, shift_next;
  logic [CW-1:0]       bit_cnt, cnt_shifted, cnt_next;
  logic [TW-1:0]       tmo_cnt, tmo_next;
  link_state_e         state, state_next;
  logic                commit, bad_len;
  logic [W-1:0]        dec_buttons;
  logic [NUM_PADS-1:0] dec_present;
  logic [W-1:0]        buttons_next, pressed_next, released_next;
  logic [NUM_PADS-1:0] present_next;
  logic                stale_next;

  // Shift happens before the length check so a coincident clk/latch fall counts its bit
  always_comb begin
    shift_next  = shift_reg;
    cnt_shifted = bit_cnt;
    if (clk_fall) begin
      shift_next = {shift_reg[W-2:0], data_sync};
      if (bit_cnt != CW'(W + 1)) cnt_shifted = bit_cnt + 1'b1;
    end
    commit   = latch_fall && (cnt_shifted == CW'(W));
    bad_len  = latch_fall && !commit;
    cnt_next = latch_fall ? '0 : cnt_shifted;
  end

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    logic [BITS_PER_PAD-1:0] slice;
    assign slice          = shift_next[k*BITS_PER_PAD +: BITS_PER_PAD];
    assign dec_present[k] = (slice != EMPTY_PAD);
    assign dec_buttons[k*BITS_PER_PAD +: BITS_PER_PAD] = dec_present[k] ? slice : '0;
  end

  always_comb begin
    state_next    = state;
    tmo_next      = tmo_cnt;
    buttons_next  = buttons;
    pressed_next  = '0;
    released_next = '0;
    present_next  = is_present;
    stale_next    = stale;
    if (commit) begin
      state_next    = LINK;
      tmo_next      = '0;
      buttons_next  = dec_buttons;
      pressed_next  = dec_buttons & ~buttons;
      released_next = ~dec_buttons & buttons;
      present_next  = dec_present;
      stale_next    = 1'b0;
    end else if (state == LINK) begin
      if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_next    = NO_LINK;
        buttons_next  = '0;
        released_next = buttons;
        present_next  = '0;
        stale_next    = 1'b1;
      end else begin
        tmo_next = tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= NO_LINK;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      buttons     <= '0;
      pressed     <= '0;
      released    <= '0;
      is_present  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      stale       <= 1'b1;
    end else begin
      state       <= state_next;
      shift_reg   <= shift_next;
      bit_cnt     <= cnt_next;
      tmo_cnt     <= tmo_next;
      buttons     <= buttons_next;
      pressed     <= pressed_next;
      released    <= released_next;
      is_present  <= present_next;
      frame_valid <= commit;
      frame_err   <= bad_len;
      stale       <= stale_next;
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_multi.sv
// tb/tb_gamepad_pmod_multi.sv - directed-vector bench for gamepad_pmod_multi
module tb_gamepad_pmod_multi;

  localparam int NP   = 2;
  localparam int SS   = 2;
  localparam int TMO  = 1024;
  localparam int W    = 12 * NP;
  localparam int WIN  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pmod_data, pmod_clk, pmod_latch;
  logic [W-1:0]  buttons, pressed, released;
  logic [NP-1:0] is_present;
  logic          frame_valid, frame_err, stale;

  int n_vec = 0;
  int n_bad = 0;

  int            lat, nv, ne;
  logic [W-1:0]  s_buttons, s_pressed, s_released;
  logic [NP-1:0] s_present;
  logic          s_stale;

  gamepad_pmod_multi #(
    .NUM_PADS(NP), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
    .buttons(buttons), .pressed(pressed), .released(released),
    .is_present(is_present), .frame_valid(frame_valid),
    .frame_err(frame_err), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n, input bit coinc);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk) pmod_data = bits[i];
      repeat (2) @(negedge clk);
      pmod_clk = 1'b1;
      if (coinc && i == 0) pmod_latch = 1'b1;
      repeat (3) @(negedge clk);
      pmod_clk = 1'b0;
      if (coinc && i == 0) pmod_latch = 1'b0;
      else repeat (3) @(negedge clk);
    end
  endtask

  task automatic watch();
    lat = 0; nv = 0; ne = 0;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      if (frame_err) ne++;
      if (frame_valid) begin
        nv++;
        if (lat == 0) begin
          lat        = c;
          s_buttons  = buttons;
          s_pressed  = pressed;
          s_released = released;
          s_present  = is_present;
          s_stale    = stale;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input bit coinc);
    shift_bits(bits, n, coinc);
    if (!coinc) begin
      pmod_latch = 1'b1;
      repeat (3) @(negedge clk);
      pmod_latch = 1'b0;
    end
    watch();
  endtask

  initial begin
    int pulses, k, rel_cnt;
    logic [W-1:0] rel_seen;

    reset = 1'b1; pmod_data = 1'b0; pmod_clk = 1'b0; pmod_latch = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_stale", stale, 1);
    check("rst_buttons", buttons, 0);
    check("rst_present", is_present, 0);

    pulses = 0;
    repeat (TMO) begin
      @(negedge clk);
      if (frame_valid || frame_err || (pressed != 0) || (released != 0)) pulses++;
    end
    check("idle_stale", stale, 1);
    check("idle_pulses", pulses, 0);
    check("idle_buttons", buttons, 0);

    // pad1 = b, pad0 = r
    send_frame(32'h800001, 24, 1'b0);
    check("f1_latency", lat, SS + 1);
    check("f1_nvalid", nv, 1);
    check("f1_buttons", s_buttons, 24'h800001);
    check("f1_pressed", s_pressed, 24'h800001);
    check("f1_stale", s_stale, 0);
    check("f1_present", s_present, 2'b11);
    check("f1_pressed_clr", pressed, 0);

    // pad1 absent
    send_frame(32'hFFF010, 24, 1'b0);
    check("f2_buttons", s_buttons, 24'h000010);
    check("f2_present", s_present, 2'b01);
    check("f2_pressed", s_pressed, 24'h000010);
    check("f2_released", s_released, 24'h800001);

    send_frame(32'h0ABCDE, 23, 1'b0);
    check("short_err", ne, 1);
    check("short_valid", nv, 0);
    check("short_buttons", buttons, 24'h000010);

    send_frame(32'h1ABCDEF, 25, 1'b0);
    check("long_err", ne, 1);
    check("long_valid", nv, 0);
    check("long_buttons", buttons, 24'h000010);

    send_frame(32'h123456, 24, 1'b0);
    check("f3_valid", nv, 1);
    check("f3_err", ne, 0);
    check("f3_buttons", s_buttons, 24'h123456);

    send_frame(32'h000801, 24, 1'b1);
    check("coinc_valid", nv, 1);
    check("coinc_err", ne, 0);
    check("coinc_buttons", s_buttons, 24'h000801);
    check("coinc_bit0", s_buttons[0], 1);

    send_frame(32'h000100, 24, 1'b0);
    check("f4_buttons", s_buttons, 24'h000100);
    check("f4_released", s_released, 24'h000801);

    k = 0; rel_cnt = 0; rel_seen = '0;
    while (!stale && k < 2 * TMO) begin
      @(negedge clk);
      k++;
      if (released != 0) begin rel_cnt++; rel_seen = released; end
    end
    check("tmo_delay", (WIN - lat) + k, TMO);
    check("tmo_released", rel_seen, 24'h000100);
    check("tmo_buttons", buttons, 0);
    check("tmo_present", is_present, 0);
    repeat (4) begin
      @(negedge clk);
      if (released != 0) rel_cnt++;
    end
    check("tmo_rel_once", rel_cnt, 1);

    send_frame(32'h000002, 24, 1'b0);
    check("relink_valid", nv, 1);
    check("relink_stale", s_stale, 0);
    check("relink_present", s_present, 2'b11);
    check("relink_buttons", s_buttons, 24'h000002);

    // partial frame interrupted by reset, then a full frame
    shift_bits(32'h3FF, 10, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("mid_rst_stale", stale, 1);
    send_frame(32'h0C0030, 24, 1'b0);
    check("mid_rst_valid", nv, 1);
    check("mid_rst_err", ne, 0);
    check("mid_rst_buttons", s_buttons, 24'h0C0030);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
